// File: rtl/sprite_blitter.sv
// Sprite blitter: composites 16x16 4-bit-indexed sprites from the sprite ROM
// into the packed frame buffer while it owns SRAM during the drawer's blank window.
module sprite_blitter #(
  parameter logic [19:0] BUFFER_START = 20'h00000,
  parameter int unsigned ROW_BYTES    = 128,
  parameter int unsigned ROWS         = 120,
  parameter int unsigned SPR_DIM      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        blitterStart,
  output logic        ackBack,
  output logic        enable,
  input  logic        acknowladge,
  output logic        inControl,
  input  logic        spr_valid,
  output logic        spr_ready,
  input  logic        spr_last,
  input  logic [8:0]  spr_x,
  input  logic [7:0]  spr_y,
  input  logic [3:0]  spr_id,
  output logic [11:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [19:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned CW = $clog2(SPR_DIM);

  typedef enum logic [3:0] {
    HANDOFF, WAIT_START, TAKE, DESC, ROM_A, ROM_D, RD, RD_LAT, WR, NEXT, RELEASE
  } state_t;

  state_t          state_q;
  logic [8:0]      x_q;
  logic [7:0]      y_q;
  logic [3:0]      id_q;
  logic            last_q;
  logic [CW-1:0]   row_q, col_q;
  logic [3:0]      pix_q;
  logic            odd_q;

  logic            ack_back_q, enable_q, in_control_q, spr_ready_q;
  logic [11:0]     rom_addr_q;
  logic [19:0]     sram_addr_q;
  logic [15:0]     dq_out_q;
  logic            dq_oe_q, ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;

  logic [9:0]      px_d;
  logic [8:0]      py_d;
  logic            clip_d;
  logic [19:0]     addr_d;
  logic [7:0]      merged_d;
  logic            col_end, row_end;
  logic [CW-1:0]   col_d, row_d;
  logic            unused_dq_hi;

  // Pixel position, clipping and byte address for the current sprite pixel
  always_comb begin
    px_d     = 10'(x_q) + 10'(col_q);
    py_d     = 9'(y_q) + 9'(row_q);
    clip_d   = (px_d >= 10'(2 * ROW_BYTES)) || (py_d >= 9'(ROWS));
    addr_d   = BUFFER_START + 20'(py_d) * 20'(ROW_BYTES) + 20'(px_d[9:1]);
    merged_d = odd_q ? {SRAM_DQ_in[7:4], pix_q} : {pix_q, SRAM_DQ_in[3:0]};
    col_end  = (col_q == CW'(SPR_DIM - 1));
    row_end  = (row_q == CW'(SPR_DIM - 1));
    col_d    = col_end ? '0 : col_q + CW'(1);
    row_d    = col_end ? row_q + CW'(1) : row_q;
  end

  assign unused_dq_hi = ^SRAM_DQ_in[15:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HANDOFF;
      x_q          <= '0;
      y_q          <= '0;
      id_q         <= '0;
      last_q       <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      pix_q        <= '0;
      odd_q        <= 1'b0;
      ack_back_q   <= 1'b0;
      enable_q     <= 1'b0;
      in_control_q <= 1'b0;
      spr_ready_q  <= 1'b0;
      rom_addr_q   <= '0;
      sram_addr_q  <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
    end else begin
      ack_back_q  <= 1'b0;
      spr_ready_q <= 1'b0;
      case (state_q)
        HANDOFF, RELEASE: begin
          in_control_q <= 1'b0;
          if (acknowladge) begin
            enable_q <= 1'b0;
            state_q  <= WAIT_START;
          end else begin
            enable_q <= 1'b1;
          end
        end
        WAIT_START: begin
          if (blitterStart) begin
            ack_back_q   <= 1'b1;
            in_control_q <= 1'b1;
            ce_n_q       <= 1'b0;
            state_q      <= TAKE;
          end
        end
        TAKE: state_q <= DESC;
        DESC: begin
          if (spr_valid) begin
            x_q         <= spr_x;
            y_q         <= spr_y;
            id_q        <= spr_id;
            last_q      <= spr_last;
            row_q       <= '0;
            col_q       <= '0;
            spr_ready_q <= 1'b1;
            rom_addr_q  <= 12'({spr_id, CW'(0), CW'(0)});
            state_q     <= ROM_A;
          end
        end
        ROM_A: state_q <= ROM_D;
        // Transparent or off-screen pixels never touch SRAM
        ROM_D: begin
          if ((rom_data == 4'h0) || clip_d) begin
            state_q <= NEXT;
          end else begin
            sram_addr_q <= addr_d;
            pix_q       <= rom_data;
            odd_q       <= px_d[0];
            oe_n_q      <= 1'b0;
            lb_n_q      <= 1'b0;
            state_q     <= RD;
          end
        end
        RD: state_q <= RD_LAT;
        RD_LAT: begin
          dq_out_q <= {8'h00, merged_d};
          oe_n_q   <= 1'b1;
          we_n_q   <= 1'b0;
          ub_n_q   <= 1'b1;
          dq_oe_q  <= 1'b1;
          state_q  <= WR;
        end
        WR: begin
          we_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          state_q <= NEXT;
        end
        NEXT: begin
          col_q <= col_d;
          row_q <= row_d;
          if (row_end && col_end) begin
            if (last_q) begin
              enable_q     <= 1'b1;
              in_control_q <= 1'b0;
              ce_n_q       <= 1'b1;
              state_q      <= RELEASE;
            end else begin
              state_q <= DESC;
            end
          end else begin
            rom_addr_q <= 12'({id_q, row_d, col_d});
            state_q    <= ROM_A;
          end
        end
        default: state_q <= HANDOFF;
      endcase
    end
  end

  assign ackBack     = ack_back_q;
  assign enable      = enable_q;
  assign inControl   = in_control_q;
  assign spr_ready   = spr_ready_q;
  assign rom_addr    = rom_addr_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_DQ_out = dq_out_q;
  assign SRAM_DQ_oe  = dq_oe_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_UB_N   = ub_n_q;
  assign SRAM_LB_N   = lb_n_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: SRAM/ROM models plus a sprite-compositing reference
// that predicts every byte write and the final frame-buffer image.
module tb_sprite_blitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        blitterStart = 1'b0, acknowladge = 1'b0;
  logic        spr_valid = 1'b0, spr_last = 1'b0;
  logic [8:0]  spr_x = '0;
  logic [7:0]  spr_y = '0;
  logic [3:0]  spr_id = '0;
  logic [3:0]  rom_data;
  logic [15:0] SRAM_DQ_in;
  logic        ackBack, enable, inControl, spr_ready, SRAM_DQ_oe;
  logic [11:0] rom_addr;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  sprite_blitter dut (
    .clk(clk), .reset(reset), .blitterStart(blitterStart), .ackBack(ackBack),
    .enable(enable), .acknowladge(acknowladge), .inControl(inControl),
    .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_last(spr_last),
    .spr_x(spr_x), .spr_y(spr_y), .spr_id(spr_id), .rom_addr(rom_addr),
    .rom_data(rom_data), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  localparam int FB_BYTES = 128 * 120;

  logic [7:0] mem      [16384];
  logic [7:0] fill_img [16384];
  logic [7:0] mdl      [16384];
  logic [3:0] rom      [4096];
  logic       fill_req = 1'b0;

  typedef struct { int x; int y; int id; } desc_t;
  typedef struct { logic [19:0] a; logic [7:0] d; } wr_t;
  desc_t dq[$];
  wr_t   exp_q[$];

  int total = 0, bad = 0;
  int wr_cnt = 0, exp_base = 0, ack_cnt = 0, rdy_cnt = 0;

  // Synchronous sprite ROM: data one cycle after address
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Asynchronous-read SRAM; junk on the bus whenever it is not being read
  always_comb SRAM_DQ_in = (!SRAM_OE_N && !SRAM_CE_N) ? {8'hA5, mem[SRAM_ADDR[13:0]]} : 16'hDEAD;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 16384; i++) mem[i] <= fill_img[i];
    end else if (!reset && !SRAM_CE_N && !SRAM_WE_N && !SRAM_LB_N) begin
      mem[SRAM_ADDR[13:0]] <= SRAM_DQ_out[7:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ackBack === 1'b1) ack_cnt++;
    if (spr_ready === 1'b1) rdy_cnt++;
  end

  // Per-cycle bus checks and write-stream comparison against the model
  always @(negedge clk) begin
    int k;
    if (inControl === 1'b0)
      chk("idle_bus", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe}), 32'b111110);
    if (SRAM_WE_N === 1'b0) begin
      k = wr_cnt - exp_base;
      chk("wr_ctl", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe, SRAM_DQ_out[15:8]}),
          32'({5'b01101, 8'h00}));
      chk("wr_in_range", 32'(SRAM_ADDR < 20'(FB_BYTES)), 32'd1);
      chk("wr_expected", 32'(k < exp_q.size()), 32'd1);
      if (k < exp_q.size()) begin
        chk("wr_addr", 32'(SRAM_ADDR), 32'(exp_q[k].a));
        chk("wr_data", 32'(SRAM_DQ_out[7:0]), 32'(exp_q[k].d));
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic prefill(input bit rnd, input logic [7:0] v);
    for (int i = 0; i < 16384; i++) begin
      fill_img[i] = rnd ? 8'($urandom) : v;
      mdl[i] = fill_img[i];
    end
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  // mode 0: solid colour, 1: checkerboard with transparent squares, 2: random
  task automatic rom_fill(input int id, input int mode, input logic [3:0] v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (mode)
          0:       rom[id*256 + r*16 + c] = v;
          1:       rom[id*256 + r*16 + c] = ((r + c) % 2 == 1) ? v : 4'h0;
          default: rom[id*256 + r*16 + c] = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(1, 15));
        endcase
  endtask

  // Reference: paint sprites in list order onto the model image
  task automatic model_frame();
    int px, py, a;
    logic [3:0] v;
    exp_base = wr_cnt;
    exp_q.delete();
    foreach (dq[s])
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          px = dq[s].x + c;
          py = dq[s].y + r;
          v  = rom[dq[s].id*256 + r*16 + c];
          if (v != 4'h0 && px < 256 && py < 120) begin
            a = py * 128 + px / 2;
            if (px % 2 == 0) mdl[a][7:4] = v;
            else             mdl[a][3:0] = v;
            exp_q.push_back('{a: 20'(a), d: mdl[a]});
          end
        end
  endtask

  task automatic run_frame(input bit noise, output int nw);
    int a0, r0, w0, cyc, nd, ndiff;
    nd = dq.size();
    model_frame();
    a0 = ack_cnt; r0 = rdy_cnt; w0 = wr_cnt;
    blitterStart = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (ackBack !== 1'b1 && cyc < 20);
    chk("take_ack", 32'(ackBack), 32'd1);
    blitterStart = 1'b0;
    for (int i = 0; i < nd; i++) begin
      if (noise) begin
        repeat ($urandom_range(0, 4)) begin
          blitterStart = 1'($urandom);
          acknowladge  = 1'($urandom);
          @(negedge clk);
          chk("stall_ctl", 32'(inControl), 32'd1);
        end
        blitterStart = 1'b0;
        acknowladge  = 1'b0;
      end
      spr_valid = 1'b1;
      spr_x     = 9'(dq[i].x);
      spr_y     = 8'(dq[i].y);
      spr_id    = 4'(dq[i].id);
      spr_last  = (i == nd - 1);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (spr_ready !== 1'b1 && cyc < 3000);
      chk("desc_taken", 32'(spr_ready), 32'd1);
      spr_valid = 1'b0;
    end
    cyc = 0;
    while (enable !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
    chk("release_en", 32'(enable), 32'd1);
    chk("release_ctl", 32'(inControl), 32'd0);
    chk("ack_pulses", 32'(ack_cnt - a0), 32'd1);
    chk("ready_pulses", 32'(rdy_cnt - r0), 32'(nd));
    nw = wr_cnt - w0;
    chk("write_count", 32'(nw), 32'(exp_q.size()));
    ndiff = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] !== mdl[i]) ndiff++;
    chk("mem_image", 32'(ndiff), 32'd0);
    acknowladge = 1'b1;
    @(negedge clk);
    acknowladge = 1'b0;
    chk("handback", 32'(enable), 32'd0);
  endtask

  initial begin
    int nw, cyc, nwr;

    // Reset values and first handoff to the drawer
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({enable, ackBack, inControl, spr_ready, SRAM_DQ_oe}), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
    chk("rst_dq_out", 32'(SRAM_DQ_out), 32'd0);
    chk("rst_n_pins", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'b11111);
    reset = 1'b0;
    @(negedge clk);
    chk("en_c1", 32'(enable), 32'd1);
    blitterStart = 1'b1;
    @(negedge clk);
    chk("en_c2", 32'(enable), 32'd1);
    blitterStart = 1'b0;
    acknowladge  = 1'b1;
    @(negedge clk);
    acknowladge = 1'b0;
    chk("en_after_ack", 32'(enable), 32'd0);
    chk("no_early_take", 32'(ack_cnt), 32'd0);

    // Solid sprite at even x
    rom_fill(2, 0, 4'h7);
    prefill(1'b0, 8'h00);
    dq = '{'{x: 10, y: 5, id: 2}};
    run_frame(1'b0, nw);
    chk("A_writes", 32'(nw), 32'd256);
    chk("A_first_byte", 32'(mem[5*128+5]), 32'h77);
    chk("A_last_byte", 32'(mem[20*128+12]), 32'h77);
    chk("A_left_clear", 32'(mem[5*128+4]), 32'h00);
    chk("A_right_clear", 32'(mem[20*128+13]), 32'h00);
    chk("A_model_pin", 32'(mdl[5*128+5]), 32'h77);

    // Odd x: partial bytes at both edges
    rom_fill(3, 0, 4'hA);
    prefill(1'b0, 8'h33);
    dq = '{'{x: 11, y: 5, id: 3}};
    run_frame(1'b0, nw);
    chk("B_byte5", 32'(mem[5*128+5]), 32'h3A);
    chk("B_byte6", 32'(mem[5*128+6]), 32'hAA);
    chk("B_byte12", 32'(mem[5*128+12]), 32'hAA);
    chk("B_byte13", 32'(mem[5*128+13]), 32'hA3);
    chk("B_model_pin", 32'(mdl[5*128+13]), 32'hA3);

    // Checkerboard transparency
    rom_fill(4, 1, 4'h9);
    prefill(1'b0, 8'h11);
    dq = '{'{x: 20, y: 30, id: 4}};
    run_frame(1'b0, nw);
    chk("C_writes", 32'(nw), 32'd128);
    chk("C_row0", 32'(mem[30*128+10]), 32'h19);
    chk("C_row1", 32'(mem[31*128+10]), 32'h91);

    // Clipping at bottom-right corner
    rom_fill(5, 0, 4'hF);
    prefill(1'b0, 8'h00);
    dq = '{'{x: 250, y: 112, id: 5}};
    run_frame(1'b0, nw);
    chk("D_writes", 32'(nw), 32'd48);
    chk("D_corner", 32'(mem[119*128+127]), 32'hFF);
    chk("D_first", 32'(mem[112*128+125]), 32'hFF);

    // Random overlapping sprite lists with stalls and ignored handshake noise
    for (int f = 0; f < 3; f++) begin
      for (int id = 0; id < 16; id++) rom_fill(id, 2, 4'h0);
      prefill(1'b1, 8'h00);
      dq.delete();
      repeat ($urandom_range(3, 5))
        dq.push_back('{x: $urandom_range(0, 300), y: $urandom_range(0, 130), id: $urandom_range(0, 15)});
      run_frame(1'b1, nw);
    end

    // Reset during the write of the third pixel
    rom_fill(12, 0, 4'hC);
    prefill(1'b0, 8'h00);
    dq = '{'{x: 0, y: 0, id: 12}};
    model_frame();
    blitterStart = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (ackBack !== 1'b1 && cyc < 20);
    blitterStart = 1'b0;
    spr_valid = 1'b1; spr_x = 9'd0; spr_y = 8'd0; spr_id = 4'd12; spr_last = 1'b1;
    nwr = 0; cyc = 0;
    while (nwr < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (spr_ready === 1'b1) spr_valid = 1'b0;
      if (SRAM_WE_N === 1'b0) nwr++;
    end
    chk("F_reached_wr3", 32'(nwr), 32'd3);
    spr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("F_we_after_reset", 32'(SRAM_WE_N), 32'd1);
    chk("F_ctl_after_reset", 32'(inControl), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("F_handoff_en", 32'(enable), 32'd1);
    chk("F_prior_writes", 32'(mem[0]), 32'hCC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
